// File: rtl/riscv_load_wb.sv
// -----------------------------------------------------------------------------
// riscv_load_wb
//
// This is the completion unit on the write-back side for data-memory accesses.
// It sits directly after the execute stage. When EX issues a granted access,
// this block records the access control: store/load, size, sign extension and
// byte offset. It then waits for the memory response. A load response is
// rotated into place and extended, and it goes straight to the register-file
// write port in the same cycle as data_rvalid_i. A store response finishes
// without any write-back. wb_ready_o is the backpressure that EX uses to gate
// ex_valid.
//
// Optional feature (macro RISCV_LOAD_WB_TIMEOUT_EN):
//   This macro adds a response timeout. It runs for TIMEOUT_CYCLES wait cycles
//   and ends with a one-cycle load_err_o pulse. The block then releases WAIT.
//   Without the macro, WAIT lasts until a response arrives and load_err_o is 0.
//
// Parameters:
//   TIMEOUT_CYCLES         response-wait limit, 1..1023 (used only with the macro)
//
// Ports:
//   clk                    clock, all state updates on the rising edge
//   rst                    synchronous active-high reset
//   ex_valid_i             an instruction leaves EX this cycle
//   data_req_ex_i          that instruction issued a granted memory access
//   data_we_ex_i           the access is a store
//   data_type_ex_i [1:0]   00 word, 01 half, 10 byte, 11 treated as word
//   data_sign_ext_ex_i     sign-extend load data
//   data_addr_ex_i [1:0]   byte offset within the word
//   data_rvalid_i          memory response valid
//   data_rdata_i   [31:0]  memory response data
//   wb_ready_o             WB can accept a new instruction this cycle
//   regfile_wdata_o[31:0]  aligned and extended load result
//   regfile_wdata_valid_o  regfile_wdata_o is valid (load response only)
//   data_misaligned_o      captured access is misaligned (informational)
//   load_err_o             response timeout pulse (0 without the macro)
// -----------------------------------------------------------------------------
module riscv_load_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [1:0]  data_addr_ex_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        wb_ready_o,
    output logic [31:0] regfile_wdata_o,
    output logic        regfile_wdata_valid_o,
    output logic        data_misaligned_o,
    output logic        load_err_o
);

    // Stop elaboration if the parameter is outside the range the counter is sized for.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("riscv_load_wb: TIMEOUT_CYCLES must be in 1..1023");
    end

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;

    state_t      state;
    logic        lat_we;
    logic [1:0]  lat_type;
    logic        lat_sign_ext;
    logic [1:0]  lat_offset;
    logic        misaligned_q;

    logic        capture;
    logic        in_wait;
    logic        timeout_hit;
    logic        cap_misaligned;
    logic [31:0] rot;

    // A capture happens when EX sends out a granted access. EX only does this
    // while wb_ready_o is high, so a capture never finds an access still pending.
    assign capture = ex_valid_i & data_req_ex_i;
    assign in_wait = (state == WAIT);

    // The access crosses the word boundary in two cases: a word access at a
    // nonzero offset, or a half access in the last byte lane. Type 11 counts
    // as a word.
    assign cap_misaligned =
        (((data_type_ex_i == TYPE_WORD) || (data_type_ex_i == 2'b11)) && (data_addr_ex_i != 2'b00)) ||
        ((data_type_ex_i == TYPE_HALF) && (data_addr_ex_i == 2'b11));

`ifdef RISCV_LOAD_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // The counter restarts on every capture, so a back-to-back re-entry gets
    // the full window. It counts only the WAIT cycles that have no response.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (capture) begin
            to_cnt <= '0;
        end else if (in_wait && !data_rvalid_i) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A response in the expiry cycle wins, so the timeout is masked by rvalid.
    assign timeout_hit = in_wait & ~data_rvalid_i & (to_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Control FSM and capture latches.
    // NOTE: all sequential state here uses non-blocking assignments, so every
    // register samples the values from before the edge; blocking assignments
    // would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register here is a flop with a defined reset value.
            // There is no storage array, so no state is left unreset.
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_type     <= 2'b00;
            lat_sign_ext <= 1'b0;
            lat_offset   <= 2'b00;
            misaligned_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A stray response in IDLE is dropped.
                    if (capture) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A capture in the completion cycle keeps WAIT for the next access.
                    if (!capture && (data_rvalid_i || timeout_hit)) begin
                        state <= IDLE;
                    end
                end
            endcase

            if (capture) begin
                lat_we       <= data_we_ex_i;
                lat_type     <= data_type_ex_i;
                lat_sign_ext <= data_sign_ext_ex_i;
                lat_offset   <= data_addr_ex_i;
                misaligned_q <= cap_misaligned;
            end
        end
    end

    // Rotate right by 8*offset so that the addressed byte moves to lane 0.
    // A misaligned access gives the same rotated value (no second beat).
    always_comb begin
        // NOTE: each combinational output gets a default first. Without one,
        // any path that skips the assignment would infer a latch.
        rot = data_rdata_i;
        unique case (lat_offset)
            2'd0: rot = data_rdata_i;
            2'd1: rot = {data_rdata_i[7:0],  data_rdata_i[31:8]};
            2'd2: rot = {data_rdata_i[15:0], data_rdata_i[31:16]};
            2'd3: rot = {data_rdata_i[23:0], data_rdata_i[31:24]};
        endcase
    end

    // Size select and extension. A word is never extended.
    always_comb begin
        regfile_wdata_o = rot;
        unique case (lat_type)
            TYPE_HALF: regfile_wdata_o = {{16{lat_sign_ext & rot[15]}}, rot[15:0]};
            TYPE_BYTE: regfile_wdata_o = {{24{lat_sign_ext & rot[7]}},  rot[7:0]};
            default:   regfile_wdata_o = rot;
        endcase
    end

    // wb_ready_o depends on registered state plus data_rvalid_i only (the
    // timeout term uses the same inputs). It has no path from ex_valid_i, so
    // there is no combinational loop through EX.
    assign wb_ready_o            = ~in_wait | data_rvalid_i | timeout_hit;
    assign regfile_wdata_valid_o = in_wait & data_rvalid_i & ~lat_we;
    assign data_misaligned_o     = misaligned_q;
    assign load_err_o            = timeout_hit;

endmodule

// File: tb/tb_riscv_load_wb.sv
// -----------------------------------------------------------------------------
// tb_riscv_load_wb
//
// This is a self-checking bench for riscv_load_wb. Every cycle, a reference
// model predicts the outputs. The model tracks the pending access as a size in
// bytes, a byte offset and a few flags. It derives load data with plain
// shifts and masks. The bench first runs the directed scenarios and then runs
// legal random traffic. EX only issues while the model says WB is ready.
// -----------------------------------------------------------------------------
module tb_riscv_load_wb;

    localparam int TO = 4;
`ifdef RISCV_LOAD_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        data_req_ex_i;
    logic        data_we_ex_i;
    logic [1:0]  data_type_ex_i;
    logic        data_sign_ext_ex_i;
    logic [1:0]  data_addr_ex_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        wb_ready_o;
    logic [31:0] regfile_wdata_o;
    logic        regfile_wdata_valid_o;
    logic        data_misaligned_o;
    logic        load_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the pending access.
    bit m_wait = 1'b0;
    bit m_we   = 1'b0;
    int m_size = 4;
    bit m_sx   = 1'b0;
    int m_off  = 0;
    bit m_mis  = 1'b0;
    int m_cnt  = 0;

    riscv_load_wb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_valid_i            (ex_valid_i),
        .data_req_ex_i         (data_req_ex_i),
        .data_we_ex_i          (data_we_ex_i),
        .data_type_ex_i        (data_type_ex_i),
        .data_sign_ext_ex_i    (data_sign_ext_ex_i),
        .data_addr_ex_i        (data_addr_ex_i),
        .data_rvalid_i         (data_rvalid_i),
        .data_rdata_i          (data_rdata_i),
        .wb_ready_o            (wb_ready_o),
        .regfile_wdata_o       (regfile_wdata_o),
        .regfile_wdata_valid_o (regfile_wdata_valid_o),
        .data_misaligned_o     (data_misaligned_o),
        .load_err_o            (load_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] typ);
        if (typ == 2'b01) return 2;
        if (typ == 2'b10) return 1;
        return 4;
    endfunction

    // Expected load result: pick the addressed bytes, then extend.
    function automatic logic [31:0] model_data(input logic [31:0] rd, input int size,
                                               input bit sx, input int off);
        logic [63:0] dbl;
        logic [31:0] rot;
        logic [31:0] mask;
        logic [31:0] val;
        dbl = {rd, rd};
        rot = 32'(dbl >> (8 * off));
        if (size == 4) return rot;
        mask = (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        val  = rot & mask;
        if (sx && rot[8 * size - 1]) val = val | ~mask;
        return val;
    endfunction

    function automatic bit model_to(input bit rv);
        return TO_EN && m_wait && !rv && (m_cnt == TO - 1);
    endfunction

    function automatic bit model_ready(input bit rv);
        return !m_wait || rv || model_to(rv);
    endfunction

    // Apply inputs, then compare all outputs against the model at mid-cycle.
    task automatic drive(input bit r, input bit ev, input bit req, input bit we,
                         input logic [1:0] typ, input bit sx, input logic [1:0] off,
                         input bit rv, input logic [31:0] rd);
        bit exp_valid;
        rst                = r;
        ex_valid_i         = ev;
        data_req_ex_i      = req;
        data_we_ex_i       = we;
        data_type_ex_i     = typ;
        data_sign_ext_ex_i = sx;
        data_addr_ex_i     = off;
        data_rvalid_i      = rv;
        data_rdata_i       = rd;
        @(negedge clk);
        exp_valid = m_wait && rv && !m_we;
        check("wb_ready",   32'(wb_ready_o),            32'(model_ready(rv)));
        check("wdata_vld",  32'(regfile_wdata_valid_o), 32'(exp_valid));
        check("misaligned", 32'(data_misaligned_o),     32'(m_mis));
        check("load_err",   32'(load_err_o),            32'(model_to(rv)));
        if (exp_valid)
            check("wdata", regfile_wdata_o, model_data(rd, m_size, m_sx, m_off));
    endtask

    // Advance one edge and update the model from the inputs applied.
    task automatic tick();
        bit cap;
        bit to;
        @(posedge clk);
        cap = ex_valid_i && data_req_ex_i;
        to  = model_to(data_rvalid_i);
        if (rst) begin
            m_wait = 0; m_we = 0; m_size = 4; m_sx = 0; m_off = 0; m_mis = 0; m_cnt = 0;
        end else if (cap) begin
            m_wait = 1;
            m_we   = data_we_ex_i;
            m_size = size_of(data_type_ex_i);
            m_sx   = data_sign_ext_ex_i;
            m_off  = int'(data_addr_ex_i);
            m_mis  = (m_off + m_size) > 4;
            m_cnt  = 0;
        end else if (m_wait && (data_rvalid_i || to)) begin
            m_wait = 0;
        end else if (m_wait) begin
            m_cnt++;
        end
        #1;
    endtask

    // Shorthands: issue an access from IDLE, and an idle/response-only cycle.
    task automatic issue(input bit we, input logic [1:0] typ, input bit sx, input logic [1:0] off);
        drive(0, 1, 1, we, typ, sx, off, 0, 32'h0);
        tick();
    endtask

    task automatic resp(input bit rv, input logic [31:0] rd);
        drive(0, 0, 0, 0, 2'b00, 0, 2'b00, rv, rd);
    endtask

    initial begin
        bit          r, rv, ev, req, we, sx;
        logic [1:0]  typ, off;
        logic [31:0] rd;

        rst = 1'b1; ex_valid_i = 0; data_req_ex_i = 0; data_we_ex_i = 0;
        data_type_ex_i = 0; data_sign_ext_ex_i = 0; data_addr_ex_i = 0;
        data_rvalid_i = 0; data_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, including a stray rvalid while reset is held.
        drive(1, 0, 0, 0, 2'b00, 0, 2'b00, 1, 32'h1234_5678);
        check("rst_ready", 32'(wb_ready_o), 32'd1);
        tick();

        // Word load, offset 0, response on the next cycle.
        issue(0, 2'b00, 0, 2'd0);
        resp(1, 32'hDEAD_BEEF);
        check("word_data",  regfile_wdata_o, 32'hDEAD_BEEF);
        check("word_vld",   32'(regfile_wdata_valid_o), 32'd1);
        check("word_ready", 32'(wb_ready_o), 32'd1);
        check("word_mis",   32'(data_misaligned_o), 32'd0);
        tick();
        resp(0, 32'h0);
        check("word_vld_off", 32'(regfile_wdata_valid_o), 32'd0);
        tick();

        // Byte load at offset 3, signed and unsigned.
        issue(0, 2'b10, 1, 2'd3);
        resp(1, 32'h80FF_1234);
        check("byte_sx", regfile_wdata_o, 32'hFFFF_FF80);
        tick();
        issue(0, 2'b10, 0, 2'd3);
        resp(1, 32'h80FF_1234);
        check("byte_zx", regfile_wdata_o, 32'h0000_0080);
        tick();

        // Half load at offset 2, with the response delayed 3 cycles.
        issue(0, 2'b01, 0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            resp(0, 32'h0);
            check("half_stall", 32'(wb_ready_o), 32'd0);
            tick();
        end
        resp(1, 32'hABCD_0011);
        check("half_data", regfile_wdata_o, 32'h0000_ABCD);
        check("half_err",  32'(load_err_o), 32'd0);
        tick();

        // Back-to-back: load A completes while misaligned store B is captured.
        issue(0, 2'b00, 0, 2'd0);
        drive(0, 1, 1, 1, 2'b00, 0, 2'd1, 1, 32'h0000_0011);
        check("b2b_a_data", regfile_wdata_o, 32'h0000_0011);
        check("b2b_a_vld",  32'(regfile_wdata_valid_o), 32'd1);
        tick();
        resp(0, 32'h0);
        check("b2b_wait", 32'(wb_ready_o), 32'd0);
        check("b2b_mis",  32'(data_misaligned_o), 32'd1);
        tick();
        resp(1, 32'hCAFE_F00D);
        check("b2b_store_vld", 32'(regfile_wdata_valid_o), 32'd0);
        tick();

        // Reset in WAIT, then a late rvalid for the aborted access.
        issue(0, 2'b00, 0, 2'd0);
        drive(1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 32'h0);
        tick();
        resp(1, 32'h5555_AAAA);
        check("late_vld",   32'(regfile_wdata_valid_o), 32'd0);
        check("late_ready", 32'(wb_ready_o), 32'd1);
        tick();

`ifdef RISCV_LOAD_WB_TIMEOUT_EN
        // Timeout: no response, so the error pulses in the 4th WAIT cycle.
        issue(0, 2'b00, 0, 2'd0);
        for (int i = 0; i < TO; i++) begin
            resp(0, 32'h0);
            check("to_err", 32'(load_err_o), (i == TO - 1) ? 32'd1 : 32'd0);
            check("to_rdy", 32'(wb_ready_o), (i == TO - 1) ? 32'd1 : 32'd0);
            tick();
        end
        resp(0, 32'h0);
        check("to_idle", 32'(wb_ready_o), 32'd1);
        tick();
        // A response in the expiry cycle takes precedence over the error.
        issue(0, 2'b00, 0, 2'd0);
        for (int i = 0; i < TO - 1; i++) begin
            resp(0, 32'h0);
            tick();
        end
        resp(1, 32'h0BAD_CAFE);
        check("to_race_err",  32'(load_err_o), 32'd0);
        check("to_race_data", regfile_wdata_o, 32'h0BAD_CAFE);
        tick();
`endif

        // Random legal traffic.
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(63) == 0);
            rv  = ($urandom_range(99) < 40);
            rd  = $urandom;
            ev  = model_ready(rv) ? 1'($urandom_range(1)) : 1'b0;
            req = ($urandom_range(3) != 0);
            we  = 1'($urandom_range(1));
            typ = 2'($urandom_range(3));
            sx  = 1'($urandom_range(1));
            off = 2'($urandom_range(3));
            drive(r, ev, req, we, typ, sx, off, rv, rd);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
